// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the board registers, validates moves and
// resolves win/draw from an external combinational win-line detector.
module ttt_game_ctrl #(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_err,
    output logic [8:0] ain,
    output logic [8:0] bin,
    input  logic [7:0] win_line,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] win_line_q
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] ain_q, ain_d;
    logic [8:0] bin_q, bin_d;
    logic       turn_q, turn_d;
    logic       err_q, err_d;
    logic       ready_q, ready_d;
    logic       over_q, over_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] wlq_q, wlq_d;
    logic [8:0] move_mask_s;

    // Square is on the board and held by neither player.
    function automatic logic sq_free(input logic [8:0] occ, input logic [3:0] pos);
        logic [15:0] occ_ext;
        occ_ext = {7'd0, occ};
        return (pos <= 4'd8) && !occ_ext[pos];
    endfunction

    assign move_mask_s = 9'd1 << move_pos;

    // Next-state logic: new_game overrides everything, then per-state behaviour.
    always_comb begin
        state_d  = state_q;
        ain_d    = ain_q;
        bin_d    = bin_q;
        turn_d   = turn_q;
        err_d    = 1'b0;
        over_d   = over_q;
        winner_d = winner_q;
        wlq_d    = wlq_q;
        if (new_game) begin
            state_d  = ST_PLAY;
            ain_d    = 9'd0;
            bin_d    = 9'd0;
            turn_d   = FIRST_PLAYER;
            over_d   = 1'b0;
            winner_d = 2'b00;
            wlq_d    = 8'd0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (move_valid) begin
                        if (sq_free(ain_q | bin_q, move_pos)) begin
                            if (turn_q) begin
                                bin_d = bin_q | move_mask_s;
                            end else begin
                                ain_d = ain_q | move_mask_s;
                            end
                            state_d = ST_CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                // Board was updated last edge; win_line now reflects it.
                ST_CHECK: begin
                    if (win_line != 8'd0) begin
                        state_d  = ST_DONE;
                        over_d   = 1'b1;
                        winner_d = turn_q ? 2'b10 : 2'b01;
                        wlq_d    = win_line;
                    end else if ((ain_q | bin_q) == 9'h1FF) begin
                        state_d  = ST_DONE;
                        over_d   = 1'b1;
                        winner_d = 2'b11;
                        wlq_d    = 8'd0;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_PLAY;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
        ready_d = (state_d == ST_PLAY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PLAY;
            ain_q    <= 9'd0;
            bin_q    <= 9'd0;
            turn_q   <= FIRST_PLAYER;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            over_q   <= 1'b0;
            winner_q <= 2'b00;
            wlq_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ain_q    <= ain_d;
            bin_q    <= bin_d;
            turn_q   <= turn_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            wlq_q    <= wlq_d;
        end
    end

    assign move_ready = ready_q;
    assign move_err   = err_q;
    assign ain        = ain_q;
    assign bin        = bin_q;
    assign turn       = turn_q;
    assign game_over  = over_q;
    assign winner     = winner_q;
    assign win_line_q = wlq_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a reference game model predicts every
// cycle's outputs, which a monitor compares after each rising edge.
module tb_ttt_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic [7:0] win_line0, win_line1;
    logic       ready0, err0, turn0, over0;
    logic       ready1, err1, turn1, over1;
    logic [8:0] ain0, bin0, ain1, bin1;
    logic [1:0] winner0, winner1;
    logic [7:0] wlq0, wlq1;

    typedef struct packed {
        logic [8:0] ain;
        logic [8:0] bin;
        logic       turn;
        logic       err;
        logic       ready;
        logic       over;
        logic [1:0] winner;
        logic [7:0] wlq;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [8:0] m_ain, m_bin;
    logic       m_turn, m_chk, m_over, m_err;
    logic [1:0] m_win;
    logic [7:0] m_wlq;

    // Reference win detector: bit0 = top row, rows, columns, then diagonals.
    function automatic logic [7:0] win_fn(input logic [8:0] b);
        logic [7:0] r;
        r[0] = (b & 9'h1C0) == 9'h1C0;
        r[1] = (b & 9'h038) == 9'h038;
        r[2] = (b & 9'h007) == 9'h007;
        r[3] = (b & 9'h124) == 9'h124;
        r[4] = (b & 9'h092) == 9'h092;
        r[5] = (b & 9'h049) == 9'h049;
        r[6] = (b & 9'h111) == 9'h111;
        r[7] = (b & 9'h054) == 9'h054;
        return r;
    endfunction

    assign win_line0 = win_fn(ain0) | win_fn(bin0);
    assign win_line1 = win_fn(ain1) | win_fn(bin1);

    ttt_game_ctrl #(.FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(ready0), .move_err(err0), .ain(ain0),
        .bin(bin0), .win_line(win_line0), .turn(turn0), .game_over(over0),
        .winner(winner0), .win_line_q(wlq0)
    );

    ttt_game_ctrl #(.FIRST_PLAYER(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
        .move_pos(move_pos), .move_ready(ready1), .move_err(err1), .ain(ain1),
        .bin(bin1), .win_line(win_line1), .turn(turn1), .game_over(over1),
        .winner(winner1), .win_line_q(wlq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop the prediction for this edge and compare.
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            a = '{ain0, bin0, turn0, err0, ready0, over0, winner0, wlq0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb @%0t: got ain=%h bin=%h turn=%b err=%b rdy=%b over=%b win=%b wl=%h want ain=%h bin=%h turn=%b err=%b rdy=%b over=%b win=%b wl=%h",
                         $time, a.ain, a.bin, a.turn, a.err, a.ready, a.over, a.winner, a.wlq,
                         e.ain, e.bin, e.turn, e.err, e.ready, e.over, e.winner, e.wlq);
            end
        end
    end

    task automatic model_clear();
        m_ain = 9'd0; m_bin = 9'd0; m_turn = 1'b0; m_chk = 1'b0;
        m_over = 1'b0; m_err = 1'b0; m_win = 2'b00; m_wlq = 8'd0;
    endtask

    // One clock cycle of stimulus; the predicted post-edge state is queued.
    task automatic step(input logic v, input logic [3:0] p, input logic ng);
        obs_t       e;
        logic [7:0] wl;
        logic [8:0] occ;
        @(negedge clk);
        move_valid = v;
        move_pos   = p;
        new_game   = ng;
        m_err      = 1'b0;
        if (ng) begin
            model_clear();
        end else if (m_chk) begin
            m_chk = 1'b0;
            wl = win_fn(m_ain) | win_fn(m_bin);
            if (wl != 8'd0) begin
                m_over = 1'b1; m_win = m_turn ? 2'b10 : 2'b01; m_wlq = wl;
            end else if ((m_ain | m_bin) == 9'h1FF) begin
                m_over = 1'b1; m_win = 2'b11; m_wlq = 8'd0;
            end else begin
                m_turn = ~m_turn;
            end
        end else if (!m_over && v) begin
            occ = m_ain | m_bin;
            if (p > 4'd8) begin
                m_err = 1'b1;
            end else if (occ[p]) begin
                m_err = 1'b1;
            end else begin
                if (m_turn) m_bin[p] = 1'b1;
                else        m_ain[p] = 1'b1;
                m_chk = 1'b1;
            end
        end
        e = '{m_ain, m_bin, m_turn, m_err, !m_chk && !m_over, m_over, m_win, m_wlq};
        sb.push_back(e);
        @(posedge clk);
        #2;
        move_valid = 1'b0;
        new_game   = 1'b0;
    endtask

    task automatic play(input logic [3:0] p);
        step(1'b1, p, 1'b0);
        step(1'b0, 4'd0, 1'b0);
    endtask

    // Asynchronous reset, held across an edge with a move pending.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        move_valid = 1'b1;
        move_pos = 4'd4;
        #1;
        checks++;
        if ({ain0, bin0, turn0, err0, over0, winner0, wlq0} !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: got ain=%h bin=%h turn=%b err=%b over=%b win=%b wl=%h want all zero",
                     ain0, bin0, turn0, err0, over0, winner0, wlq0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ain0, bin0, ain1, bin1} !== 36'd0 || turn1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: got ain=%h bin=%h ain_b=%h bin_b=%h turn_b=%b want 0 0 0 0 1",
                     ain0, bin0, ain1, bin1, turn1);
        end
        @(negedge clk);
        move_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b want 1/1", ready0, ready1);
        end
        model_clear();
        sb.delete();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ain0, bin0, turn0, err0, over0, winner0, wlq0} !== 32'd0) begin
            errors++;
            $display("FAIL reset_init: got ain=%h bin=%h turn=%b over=%b want zeros", ain0, bin0, turn0, over0);
        end
        do_reset();
    endtask

    task automatic test_row_win();
        step(1'b0, 4'd0, 1'b1);
        play(4'd8); play(4'd5); play(4'd7); play(4'd4); play(4'd6);
        checks++;
        if ({ain0, winner0, over0, wlq0, ready0} !== {9'h1C0, 2'b01, 1'b1, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL row_win: got ain=%h win=%b over=%b wl=%h rdy=%b want 1c0 01 1 01 0",
                     ain0, winner0, over0, wlq0, ready0);
        end
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        checks++;
        if (ain0 !== 9'h1C0 || bin0 !== 9'h030 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got ain=%h bin=%h err=%b want 1c0 030 0", ain0, bin0, err0);
        end
    endtask

    task automatic test_errors();
        step(1'b0, 4'd0, 1'b1);
        play(4'd4);
        step(1'b1, 4'd4, 1'b0);
        checks++;
        if (err0 !== 1'b1 || bin0 !== 9'h000 || turn0 !== 1'b1) begin
            errors++;
            $display("FAIL occupied: got err=%b bin=%h turn=%b want 1 000 1", err0, bin0, turn0);
        end
        step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd9, 1'b0);
        checks++;
        if (err0 !== 1'b1 || bin0 !== 9'h000) begin
            errors++;
            $display("FAIL pos9: got err=%b bin=%h want 1 000", err0, bin0);
        end
        step(1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_draw();
        step(1'b0, 4'd0, 1'b1);
        play(4'd4); play(4'd0); play(4'd8); play(4'd2); play(4'd1);
        play(4'd7); play(4'd6); play(4'd5); play(4'd3);
        checks++;
        if ({ain0, bin0, winner0, over0, wlq0} !== {9'h15A, 9'h0A5, 2'b11, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL draw: got ain=%h bin=%h win=%b over=%b wl=%h want 15a 0a5 11 1 00",
                     ain0, bin0, winner0, over0, wlq0);
        end
    endtask

    task automatic test_ninth_win();
        step(1'b0, 4'd0, 1'b1);
        play(4'd4); play(4'd5); play(4'd1); play(4'd0); play(4'd3);
        play(4'd6); play(4'd2); play(4'd8); play(4'd7);
        checks++;
        if ({ain0, bin0, winner0, over0, wlq0} !== {9'h09E, 9'h161, 2'b01, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL ninth_win: got ain=%h bin=%h win=%b over=%b wl=%h want 09e 161 01 1 10",
                     ain0, bin0, winner0, over0, wlq0);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k[3:0], 1'b0);
        end
        checks++;
        if (ain0 !== 9'h011 || bin0 !== 9'h044 || turn0 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got ain=%h bin=%h turn=%b want 011 044 0", ain0, bin0, turn0);
        end
    endtask

    task automatic test_new_game_check();
        step(1'b0, 4'd0, 1'b1);
        play(4'd8); play(4'd5); play(4'd7); play(4'd4);
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if ({ain0, bin0, turn0, over0, winner0, ready0} !== {9'h000, 9'h000, 1'b0, 1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL newgame_check: got ain=%h bin=%h turn=%b over=%b win=%b rdy=%b want 0 0 0 0 00 1",
                     ain0, bin0, turn0, over0, winner0, ready0);
        end
    endtask

    task automatic test_midgame_reset();
        step(1'b0, 4'd0, 1'b1);
        play(4'd3);
        step(1'b1, 4'd3, 1'b0);
        do_reset();
        play(4'd0); play(4'd1);
        step(1'b1, 4'd2, 1'b0);
        do_reset();
        step(1'b0, 4'd0, 1'b0);
        checks++;
        if ({ain0, bin0, turn0, over0, err0} !== 21'd0) begin
            errors++;
            $display("FAIL midgame_reset: got ain=%h bin=%h turn=%b over=%b err=%b want zeros",
                     ain0, bin0, turn0, over0, err0);
        end
    endtask

    task automatic test_first_player();
        do_reset();
        step(1'b1, 4'd4, 1'b0);
        checks++;
        if (bin1 !== 9'h010 || ain1 !== 9'h000) begin
            errors++;
            $display("FAIL first_b_move: got ain_b=%h bin_b=%h want 000 010", ain1, bin1);
        end
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        checks++;
        if (turn1 !== 1'b1 || bin1 !== 9'h000 || over1 !== 1'b0) begin
            errors++;
            $display("FAIL first_b_newgame: got turn_b=%b bin_b=%h over_b=%b want 1 000 0", turn1, bin1, over1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        new_game = 1'b0;
        move_valid = 1'b0;
        move_pos = 4'd0;
        model_clear();
        test_reset();
        test_row_win();
        test_errors();
        test_draw();
        test_ninth_win();
        test_back_to_back();
        test_new_game_check();
        test_midgame_reset();
        test_first_player();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
